// File: rtl/rv_mem_arb.sv
// Round-robin arbiter sharing one fixed-latency memory port between the core
// control plane (cpu) and the debug/program-loader port (dbg).
module rv_mem_arb #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          cpu_gnt,
    output logic          dbg_gnt,
    output logic          cpu_rvalid,
    output logic          dbg_rvalid,
    output logic [DW-1:0] rdata,
    output logic          cpu_stall,
    output logic          busy,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_RESP
    } state_t;

    localparam int CW = $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0] LAT_M1 = CW'(MEM_LAT - 1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic          r_win_dbg;
    logic          r_last_dbg;
    logic [DW-1:0] r_rdata;
    logic          r_cpu_gnt;
    logic          r_dbg_gnt;
    logic          r_cpu_rvalid;
    logic          r_dbg_rvalid;
    logic          r_mem_req;
    logic          r_mem_we;

    logic          w_any_req;
    logic          w_pick_dbg;
    logic          w_sel_we;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;

    // On a tie, the requester that was not served last wins.
    assign w_any_req   = cpu_req | dbg_req;
    assign w_pick_dbg  = dbg_req & (~cpu_req | ~r_last_dbg);
    assign w_sel_we    = w_pick_dbg ? dbg_we    : cpu_we;
    assign w_sel_addr  = w_pick_dbg ? dbg_addr  : cpu_addr;
    assign w_sel_wdata = w_pick_dbg ? dbg_wdata : cpu_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_win_dbg    <= 1'b0;
            r_last_dbg   <= 1'b1;
            r_rdata      <= '0;
            r_cpu_gnt    <= 1'b0;
            r_dbg_gnt    <= 1'b0;
            r_cpu_rvalid <= 1'b0;
            r_dbg_rvalid <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every branch reads the pre-edge
            // state; the pulse outputs default low and are raised for one cycle.
            r_cpu_gnt    <= 1'b0;
            r_dbg_gnt    <= 1'b0;
            r_cpu_rvalid <= 1'b0;
            r_dbg_rvalid <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_win_dbg  <= w_pick_dbg;
                        r_last_dbg <= w_pick_dbg;
                        r_we       <= w_sel_we;
                        r_addr     <= w_sel_addr;
                        r_wdata    <= w_sel_wdata;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= w_sel_we;
                        r_cpu_gnt  <= ~w_pick_dbg;
                        r_dbg_gnt  <= w_pick_dbg;
                        r_state    <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (r_we) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt   <= LAT_M1;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Count reaches zero in the cycle the memory presents data.
                    if (r_cnt == '0) begin
                        r_rdata      <= mem_rdata;
                        r_cpu_rvalid <= ~r_win_dbg;
                        r_dbg_rvalid <= r_win_dbg;
                        r_state      <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cpu_gnt    = r_cpu_gnt;
    assign dbg_gnt    = r_dbg_gnt;
    assign cpu_rvalid = r_cpu_rvalid;
    assign dbg_rvalid = r_dbg_rvalid;
    assign rdata      = r_rdata;
    assign busy       = (r_state != S_IDLE);
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    // Freezes the control-plane FSM until its access is actually issued.
    assign cpu_stall  = cpu_req & ~r_cpu_gnt;

endmodule
